cmplx_mul_seq: RTL and testbench

//  Sequenced complex multiplier: (ar + j*ai) * (br + j*bi) from one shared vedic32 multiplier.
//  The four partial products are computed over four cycles and accumulated into re/im.

---
 rtl/cmul_pkg.sv | 21 ++
 rtl/vedic32.sv | 17 +
 rtl/cmplx_mul_seq.sv | 154 +++++++++++++++
 tb/tb_cmplx_mul_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cmul_pkg.sv
// Shared constants, FSM state and partial-product step encoding for cmplx_mul_seq.
package cmul_pkg;

    localparam int unsigned W  = 32;
    localparam int unsigned PW = 64;
    localparam int unsigned OW = 66;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [1:0] step_t;

    localparam step_t STEP_RR = 2'd0;  // ar*br
    localparam step_t STEP_II = 2'd1;  // ai*bi
    localparam step_t STEP_RI = 2'd2;  // ar*bi
    localparam step_t STEP_IR = 2'd3;  // ai*br

endpackage

// File: rtl/vedic32.sv
// 32x32 unsigned combinational multiplier, vertically-crosswise over 16-bit halves.
module vedic32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p
);

    logic [31:0] ll, lh, hl, hh;

    assign ll = 32'(a[15:0])  * 32'(b[15:0]);
    assign lh = 32'(a[15:0])  * 32'(b[31:16]);
    assign hl = 32'(a[31:16]) * 32'(b[15:0]);
    assign hh = 32'(a[31:16]) * 32'(b[31:16]);

    assign p = {hh, ll} + (64'(lh) << 16) + (64'(hl) << 16);

endmodule

// File: rtl/cmplx_mul_seq.sv
// Sequenced complex multiplier: four partial products from one vedic32, accumulated into re/im.
// Optional feature macro: CMUL_CONJ_EN adds the conj_b port (multiply by conj(B)).
module cmplx_mul_seq
    import cmul_pkg::*;
#(
    parameter int unsigned W        = 32,
    parameter int unsigned PROD_REG = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  ar,
    input  logic [W-1:0]  ai,
    input  logic [W-1:0]  br,
    input  logic [W-1:0]  bi,
`ifdef CMUL_CONJ_EN
    input  logic          conj_b,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] re,
    output logic [OW-1:0] im,
    output logic          busy
);

    if (W != cmul_pkg::W) begin : g_bad_w
        $error("cmplx_mul_seq: W must be 32 to match vedic32");
    end

    state_t          state, state_nx;
    step_t           step;
    logic            drain;
    logic [W-1:0]    ar_q, ai_q, br_q, bi_q;
    logic [W-1:0]    mul_a, mul_b;
    logic [PW-1:0]   prod;
    logic            acc_v;
    step_t           acc_step;
    logic [PW-1:0]   acc_p;
    logic [OW-1:0]   pz;
    logic            conj;
    logic            accept;

    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign pz       = OW'(acc_p);

`ifdef CMUL_CONJ_EN
    logic conj_q;
    always_ff @(posedge clk) begin
        if (rst)         conj_q <= 1'b0;
        else if (accept) conj_q <= conj_b;
    end
    assign conj = conj_q;
`else
    assign conj = 1'b0;
`endif

    // Operand select for the shared multiplier
    always_comb begin
        mul_a = ai_q;
        mul_b = br_q;
        unique case (step)
            STEP_RR: begin mul_a = ar_q; mul_b = br_q; end
            STEP_II: begin mul_a = ai_q; mul_b = bi_q; end
            STEP_RI: begin mul_a = ar_q; mul_b = bi_q; end
            STEP_IR: begin mul_a = ai_q; mul_b = br_q; end
        endcase
    end

    vedic32 u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (prod)
    );

    // Accumulation sees either the live product or the one issued a cycle earlier
    if (PROD_REG != 0) begin : g_prod_reg
        always_ff @(posedge clk) begin
            if (rst) begin
                acc_v    <= 1'b0;
                acc_step <= STEP_RR;
                acc_p    <= '0;
            end else begin
                acc_v    <= (state == MUL) && !drain;
                acc_step <= step;
                acc_p    <= prod;
            end
        end
    end else begin : g_prod_comb
        always_comb begin
            acc_v    = (state == MUL);
            acc_step = step;
            acc_p    = prod;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = MUL;
            MUL:     if (acc_v && (acc_step == STEP_IR)) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            re        <= '0;
            im        <= '0;
            step      <= STEP_RR;
            drain     <= 1'b0;
            ar_q      <= '0;
            ai_q      <= '0;
            br_q      <= '0;
            bi_q      <= '0;
        end else begin
            out_valid <= (state_nx == DONE);
            busy      <= (state_nx != IDLE);
            if (accept) begin
                ar_q  <= ar;
                ai_q  <= ai;
                br_q  <= br;
                bi_q  <= bi;
                re    <= '0;
                im    <= '0;
                step  <= STEP_RR;
                drain <= 1'b0;
            end else if (state == MUL) begin
                if (!drain) begin
                    if (step == STEP_IR) drain <= 1'b1;
                    else                 step  <= step + 2'd1;
                end
                if (acc_v) begin
                    unique case (acc_step)
                        STEP_RR: re <= re + pz;
                        STEP_II: re <= conj ? re + pz : re - pz;
                        STEP_RI: im <= conj ? im - pz : im + pz;
                        STEP_IR: im <= im + pz;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_cmplx_mul_seq.sv
// Scoreboard bench for cmplx_mul_seq: driver pushes expected results, negedge monitor pops and compares.
module tb_cmplx_mul_seq;

    typedef struct {
        logic [65:0] re;
        logic [65:0] im;
        int          lat;
    } item_t;

    logic        clk, rst, out_ready, conj_b;
    logic        in_valid0, in_ready0, out_valid0, busy0;
    logic        in_valid1, in_ready1, out_valid1, busy1;
    logic [31:0] ar, ai, br, bi;
    logic [65:0] re0, im0, re1, im1;

    item_t q0[$];
    item_t q1[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    acc0 = 0, acc1 = 0;
    logic  ov0_prev = 1'b0, ov1_prev = 1'b0;

    cmplx_mul_seq #(.W(32), .PROD_REG(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .ar(ar), .ai(ai), .br(br), .bi(bi),
`ifdef CMUL_CONJ_EN
        .conj_b(conj_b),
`endif
        .out_valid(out_valid0), .out_ready(out_ready),
        .re(re0), .im(im0), .busy(busy0)
    );

    cmplx_mul_seq #(.W(32), .PROD_REG(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .ar(ar), .ai(ai), .br(br), .bi(bi),
`ifdef CMUL_CONJ_EN
        .conj_b(conj_b),
`endif
        .out_valid(out_valid1), .out_ready(out_ready),
        .re(re1), .im(im1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Monitor: latency on out_valid rise, result compare on handshake
    always @(negedge clk) begin
        item_t it;
        if (in_valid0 && in_ready0) acc0 = cyc + 1;
        if (in_valid1 && in_ready1) acc1 = cyc + 1;
        if (out_valid0 && !ov0_prev && q0.size() > 0) chk("lat0", 66'(cyc - acc0), 66'(q0[0].lat));
        if (out_valid1 && !ov1_prev && q1.size() > 0) chk("lat1", 66'(cyc - acc1), 66'(q1[0].lat));
        if (out_valid0 && out_ready) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected0 actual re=%h required no result", re0);
            end else begin
                it = q0.pop_front();
                chk("re0", re0, it.re);
                chk("im0", im0, it.im);
            end
        end
        if (out_valid1 && out_ready) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected1 actual re=%h required no result", re1);
            end else begin
                it = q1.pop_front();
                chk("re1", re1, it.re);
                chk("im1", im1, it.im);
            end
        end
        ov0_prev = out_valid0;
        ov1_prev = out_valid1;
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge
    task automatic send(input int which, input logic [31:0] a_r, a_i, b_r, b_i, input logic c,
                        input logic [65:0] er, ei, input int lat, input bit push);
        bit ok = 0;
        item_t it;
        ar = a_r; ai = a_i; br = b_r; bi = b_i; conj_b = c;
        if (which == 0) in_valid0 = 1'b1; else in_valid1 = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((which == 0) ? in_ready0 : in_ready1) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (ok) begin
            it.re = er; it.im = ei; it.lat = lat;
            if (push) begin
                if (which == 0) q0.push_back(it); else q1.push_back(it);
            end
            @(posedge clk); #1;
        end else begin
            checks++; errors++;
            $display("FAIL accept_timeout actual in_ready=0 required 1");
        end
        in_valid0 = 1'b0; in_valid1 = 1'b0;
        ar = $urandom; ai = $urandom; br = $urandom; bi = $urandom; conj_b = 1'b0;
    endtask

    task automatic drain_q(input int which);
        bit done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (((which == 0) ? q0.size() : q1.size()) == 0) begin done = 1; break; end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL result_timeout actual pending=%0d required 0", (which == 0) ? q0.size() : q1.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual running required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        item_t it;
        rst = 1'b1; out_ready = 1'b1; conj_b = 1'b0;
        in_valid0 = 1'b0; in_valid1 = 1'b0;
        ar = '0; ai = '0; br = '0; bi = '0;

        // Reset state
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_in_ready", 66'(in_ready0), 66'(0));
        chk("rst_out_valid", 66'(out_valid0), 66'(0));
        chk("rst_re", re0, 66'(0));
        chk("rst_im", im0, 66'(0));
        chk("rst_busy", 66'(busy0), 66'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 66'(in_ready0), 66'(1));
        @(posedge clk); #1;

        // Basic, all-ones and most-negative real
        send(0, 32'd3, 32'd4, 32'd5, 32'd6, 1'b0, -66'sd9, 66'd38, 4, 1);
        drain_q(0);
        send(0, '1, '1, '1, '1, 1'b0, 66'd0, 66'h1_FFFF_FFFC_0000_0002, 4, 1);
        drain_q(0);
        send(0, 32'd0, '1, 32'd0, '1, 1'b0, 66'h3_0000_0001_FFFF_FFFF, 66'd0, 4, 1);
        drain_q(0);

        // Backpressure with a pending operand set
        out_ready = 1'b0;
        send(0, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 66'd1, 66'd23, 4, 1);
        for (int i = 0; i < 20 && !out_valid0; i++) @(negedge clk);
        @(posedge clk); #1;
        in_valid0 = 1'b1; ar = 32'd10; ai = 32'd0; br = 32'd0; bi = 32'd10;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 66'(out_valid0), 66'(1));
            chk("bp_re", re0, 66'd1);
            chk("bp_im", im0, 66'd23);
            chk("bp_in_ready", 66'(in_ready0), 66'(0));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("hs_in_ready", 66'(in_ready0), 66'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("after_hs_in_ready", 66'(in_ready0), 66'(1));
        it.re = 66'd0; it.im = 66'd100; it.lat = 4;
        q0.push_back(it);
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        drain_q(0);

        // Reset during step 2 aborts the operation
        send(0, 32'd100, 32'd200, 32'd3, 32'd4, 1'b0, 66'd0, 66'd0, 4, 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_out_valid", 66'(out_valid0), 66'(0));
        chk("abort_re", re0, 66'd0);
        chk("abort_im", im0, 66'd0);
        chk("abort_busy", 66'(busy0), 66'(0));
        chk("abort_in_ready", 66'(in_ready0), 66'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_idle", 66'(in_ready0), 66'(1));
        @(posedge clk); #1;
        send(0, 32'd1, 32'd1, 32'd1, 32'd1, 1'b0, 66'd0, 66'd2, 4, 1);
        drain_q(0);

`ifdef CMUL_CONJ_EN
        send(0, 32'd3, 32'd4, 32'd5, 32'd6, 1'b1, 66'd39, 66'd2, 4, 1);
        drain_q(0);
        send(0, '1, '1, '1, '1, 1'b1, 66'h1_FFFF_FFFC_0000_0002, 66'd0, 4, 1);
        drain_q(0);
`endif

        // Registered-product variant: one extra cycle of latency
        send(1, 32'd3, 32'd4, 32'd5, 32'd6, 1'b0, -66'sd9, 66'd38, 5, 1);
        drain_q(1);
        send(1, '1, '1, '1, '1, 1'b0, 66'd0, 66'h1_FFFF_FFFC_0000_0002, 5, 1);
        drain_q(1);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
